ram_scan_ctrl: RTL
==================

RAM_SCAN_CTRL -- requirements
Module: ram_scan_ctrl

Interface
REQ-001 Parameter: TICK_CYCLES, 50000000, clock cycles between scan reads; legal range 4 to 2^26.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 wr_req  input  1  user write request, level.
REQ-005 wr_addr  input  5  user write address.
REQ-006 wr_data  input  3  user write data.
REQ-007 wr_ack  output  1  one-cycle pulse; the accepted write is being committed this cycle.
REQ-008 Address  output  5  address to the 32x3 memory.
REQ-009 Write  output  1  memory write enable; 1 = write, 0 = read.
REQ-010 DataIn  output  3  data to the memory.
REQ-011 DataOut  input  3  memory read data; combinational function of Address.
REQ-012 rd_addr  output  5  address of the most recent scan read.
REQ-013 rd_data  output  3  data of the most recent scan read.
REQ-014 rd_valid  output  1  one-cycle pulse; rd_addr/rd_data updated this cycle.

Function
REQ-015 The block SHALL act as sole initiator for one 32x3 memory: it writes user data and reads the array sequentially, one address per tick.
REQ-016 Tick counter SHALL count 0..TICK_CYCLES-1 and wrap; in the cycle it equals TICK_CYCLES-1 it SHALL set read_pend at that edge.
REQ-017 read_pend is a single flag: a tick while already set SHALL be absorbed, with no queueing.
REQ-018 FSM states: IDLE, WRITE, READ; every state other than IDLE SHALL last exactly one cycle.
REQ-019 IDLE: Write=0, Address=scan_ptr, DataIn=0.
REQ-020 IDLE transition priority SHALL be: (1) read_pend=1 and the previous state was WRITE -> READ; (2) wr_req=1 -> WRITE; (3) read_pend=1 -> READ; (4) otherwise stay in IDLE.
REQ-021 On the IDLE->WRITE edge, the block SHALL latch wr_addr and wr_data; changes to those inputs afterwards SHALL have no effect.
REQ-022 WRITE: Write=1, Address=latched addr, DataIn=latched data, wr_ack=1; next state IDLE.
REQ-023 Handshake: the requester SHALL drop wr_req in the wr_ack cycle; wr_req still high on return to IDLE SHALL be treated as a new request.
REQ-024 READ: Write=0, Address=scan_ptr. At the exit edge the block SHALL set rd_data<=DataOut, rd_addr<=scan_ptr, rd_valid<=1 (for one cycle), scan_ptr<=scan_ptr+1 mod 32, and read_pend<=0. Next state IDLE.
REQ-025 If a tick sets read_pend in the same edge that READ clears it, the set SHALL win.
REQ-026 scan_ptr SHALL wrap 31 -> 0 with no gap cycle.
REQ-027 A write to address A followed by a scan read of A SHALL return the written data.
REQ-028 Read latency: with no write, rd_valid SHALL assert exactly 2 cycles after the edge that sets read_pend (IDLE->READ edge, then READ exit edge).
REQ-029 All outputs SHALL be driven from registers or FSM state; there SHALL be no combinational path from wr_req to Write.

Reset
REQ-030 While Reset=1 at an edge, the block SHALL set state=IDLE, scan_ptr=0, tick counter=0, read_pend=0, latched addr/data=0, rd_addr=0, rd_data=0, rd_valid=0.
REQ-031 Following that reset edge, the block SHALL output Write=0, wr_ack=0, Address=0, DataIn=0.
REQ-032 Reset asserted during WRITE or READ SHALL abort the operation: no rd_valid pulse, Write=0 from the next cycle, and scanning restarts at address 0.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Verification (TICK_CYCLES=4)
REQ-034 Preload address k with k mod 8, no writes -> rd_valid pulses every 4 cycles with rd_addr 0,1,...,31,0,1 and rd_data = rd_addr mod 8.
REQ-035 wr_req with wr_addr=0, wr_data=7 in IDLE -> next cycle Write=1, Address=0, DataIn=7, wr_ack=1 for one cycle; the next scan read of address 0 gives rd_data=7.
REQ-036 wr_req (addr=scan_ptr=5, data=3) in the same IDLE cycle read_pend is set -> WRITE then READ; rd_addr=5, rd_data=3.
REQ-037 wr_req held high continuously with ticks running -> state sequence includes ...WRITE, IDLE, READ...; no scan read is lost and rd_addr increments by 1 per tick.
REQ-038 Reset asserted during a WRITE cycle -> Write=0 and wr_ack=0 next cycle, all outputs at reset values, and the first later rd_valid shows rd_addr=0.

Source files
------------

// File: rtl/ram_scan_ctrl.sv
// Sole initiator for a 32x3 memory: commits user writes and scans the array,
// reading one address per TICK_CYCLES-cycle tick.
module ram_scan_ctrl #(
  parameter int TICK_CYCLES = 50000000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       wr_req,
  input  logic [4:0] wr_addr,
  input  logic [2:0] wr_data,
  output logic       wr_ack,
  output logic [4:0] Address,
  output logic       Write,
  output logic [2:0] DataIn,
  input  logic [2:0] DataOut,
  output logic [4:0] rd_addr,
  output logic [2:0] rd_data,
  output logic       rd_valid
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state_q, state_d;
  logic          prev_write_q, prev_write_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          read_pend_q, read_pend_d;
  logic [4:0]    scan_ptr_q, scan_ptr_d;
  logic [4:0]    lat_addr_q, lat_addr_d;
  logic [2:0]    lat_data_q, lat_data_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [2:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          tick_hit;

  always_comb begin
    state_d      = state_q;
    prev_write_d = (state_q == WRITE);
    read_pend_d  = read_pend_q;
    scan_ptr_d   = scan_ptr_q;
    lat_addr_d   = lat_addr_q;
    lat_data_d   = lat_data_q;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;

    tick_hit = (tick_q == TICK_LAST);
    tick_d   = tick_hit ? '0 : tick_q + CW'(1);

    case (state_q)
      IDLE: begin
        // A pending read that waited behind a write goes first, so a
        // continuously held wr_req cannot starve the scan.
        if (read_pend_q && prev_write_q) begin
          state_d = READ;
        end else if (wr_req) begin
          state_d    = WRITE;
          lat_addr_d = wr_addr;
          lat_data_d = wr_data;
        end else if (read_pend_q) begin
          state_d = READ;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      READ: begin
        state_d     = IDLE;
        rd_data_d   = DataOut;
        rd_addr_d   = scan_ptr_q;
        rd_valid_d  = 1'b1;
        scan_ptr_d  = scan_ptr_q + 5'd1;
        read_pend_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Placed after the READ clear so a coincident tick is not lost.
    if (tick_hit) begin
      read_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      prev_write_q <= 1'b0;
      tick_q       <= '0;
      read_pend_q  <= 1'b0;
      scan_ptr_q   <= '0;
      lat_addr_q   <= '0;
      lat_data_q   <= '0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_write_q <= prev_write_d;
      tick_q       <= tick_d;
      read_pend_q  <= read_pend_d;
      scan_ptr_q   <= scan_ptr_d;
      lat_addr_q   <= lat_addr_d;
      lat_data_q   <= lat_data_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Memory-side outputs are pure decodes of the state register.
  always_comb begin
    Write   = (state_q == WRITE);
    wr_ack  = (state_q == WRITE);
    Address = (state_q == WRITE) ? lat_addr_q : scan_ptr_q;
    DataIn  = (state_q == WRITE) ? lat_data_q : 3'd0;
  end

  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
